// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_pkg
// Purpose  : Shared types for the EX/MEM pipeline boundary of the LEGv8
//            datapath: payload widths, the memory/writeback control bundle,
//            the packed payload record carried through the boundary, and the
//            occupancy encoding used by the skid buffer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  // Field order matches the 5-bit control bus {branch, mem_read, mem_write,
  // reg_write, mem_to_reg}, so a plain cast maps bus bits onto fields.
  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] pc_branch;
    logic [REG_W-1:0]  rd;
    ctrl_t             ctrl;
  } ex_mem_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);

  // Occupancy of the 2-entry skid buffer. Bit 0 is the head (main) valid,
  // bit 1 the skid valid; the skid is only ever occupied behind a full head,
  // so 2'b10 is unreachable.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_HEAD  = 2'b01,
    BUF_BOTH  = 2'b11
  } buf_state_t;

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_buf
// Purpose  : Generic 2-entry valid/ready skid buffer with synchronous flush.
//            in_ready comes straight from a register, so a downstream stall
//            never produces a combinational ready path back upstream.
// Ports    : clk, reset (async, active-high), flush (sync squash)
//            in_valid / in_ready / in_data    - upstream handshake + payload
//            out_valid / out_ready / out_data - downstream handshake + payload
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_t       state;
  buf_state_t       state_next;

  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;

  logic             accept;
  logic             pop;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign out_valid = (state != BUF_EMPTY);
  assign in_ready  = (state != BUF_BOTH);
  assign out_data  = main_data;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Occupancy state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BUF_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and load decisions
  // --------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    if (flush) begin
      // Squash wins over accept and pop; nothing is loaded, so any incoming
      // entry is dropped and payload registers keep their old contents.
      state_next = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_next   = BUF_HEAD;
          end
        end

        BUF_HEAD: begin
          if (pop && accept) begin
            // Pass-through: the new entry replaces the leaving head directly.
            load_main_in = 1'b1;
          end else if (pop) begin
            state_next = BUF_EMPTY;
          end else if (accept) begin
            // Head is stalled; park the new entry so upstream sees the stall
            // only on the following cycle.
            load_skid  = 1'b1;
            state_next = BUF_BOTH;
          end
        end

        BUF_BOTH: begin
          // in_ready is low here, so only a pop can change anything.
          if (pop) begin
            load_main_skid = 1'b1;
            state_next     = BUF_HEAD;
          end
        end

        default: begin
          state_next = BUF_EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Payload registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_data <= skid_data;
      end

      if (load_skid) begin
        skid_data <= in_data;
      end
    end
  end

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : EX/MEM pipeline boundary of the 64-bit LEGv8 datapath. Registers
//            the ALU result, zero flag, store data, branch target, destination
//            register and memory/writeback control through a 2-entry skid
//            buffer, and resolves CBZ/B from the registered head entry.
// Ports    : clk, reset (async, active-high), flush (sync squash)
//            in_valid/in_ready + in_alu_result, in_zero, in_write_data,
//              in_pc_branch, in_rd, in_ctrl   - from execute
//            out_valid/out_ready + out_alu_result, out_zero, out_write_data,
//              out_pc_branch, out_rd, out_ctrl - to data memory
//            branch_taken - head is a valid branch with its zero flag set
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
  parameter int DATA_W = ex_mem_pkg::DATA_W,
  parameter int REG_W  = ex_mem_pkg::REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [DATA_W-1:0] in_pc_branch,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [4:0]        in_ctrl,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_write_data,
  output logic [DATA_W-1:0] out_pc_branch,
  output logic [REG_W-1:0]  out_rd,
  output logic [4:0]        out_ctrl,

  output logic              branch_taken
);

  // The payload record is fixed by the package; DATA_W/REG_W here must match
  // the package widths for the field assignments below to be lossless.
  ex_mem_pkg::ex_mem_t payload_in;
  ex_mem_pkg::ex_mem_t payload_out;
  ex_mem_pkg::ctrl_t   head_ctrl;

  always_comb begin
    payload_in            = '0;
    payload_in.alu_result = in_alu_result;
    payload_in.zero       = in_zero;
    payload_in.write_data = in_write_data;
    payload_in.pc_branch  = in_pc_branch;
    payload_in.rd         = in_rd;
    payload_in.ctrl       = ex_mem_pkg::ctrl_t'(in_ctrl);
  end

  pipe_skid_buf #(
    .WIDTH (ex_mem_pkg::EX_MEM_W)
  ) u_skid_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (payload_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (payload_out)
  );

  assign head_ctrl      = payload_out.ctrl;

  assign out_alu_result = payload_out.alu_result;
  assign out_zero       = payload_out.zero;
  assign out_write_data = payload_out.write_data;
  assign out_pc_branch  = payload_out.pc_branch;
  assign out_rd         = payload_out.rd;
  assign out_ctrl       = payload_out.ctrl;

  // Payload may be stale after a pop or flush, so gate with the head valid.
  assign branch_taken   = out_valid & head_ctrl.branch & payload_out.zero;

endmodule : ex_mem_stage
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Self-checking bench for ex_mem_stage. A queue scoreboard holds
//            the entries expected to be buffered; a stimulus table covers
//            streaming and backpressure; short hand-written sequences cover
//            reset, branch resolution, flush and stall stability.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

  localparam int DW = 64;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_alu_result;
  logic          in_zero;
  logic [DW-1:0] in_write_data;
  logic [DW-1:0] in_pc_branch;
  logic [RW-1:0] in_rd;
  logic [4:0]    in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_alu_result;
  logic          out_zero;
  logic [DW-1:0] out_write_data;
  logic [DW-1:0] out_pc_branch;
  logic [RW-1:0] out_rd;
  logic [4:0]    out_ctrl;
  logic          branch_taken;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_result  (in_alu_result),
    .in_zero        (in_zero),
    .in_write_data  (in_write_data),
    .in_pc_branch   (in_pc_branch),
    .in_rd          (in_rd),
    .in_ctrl        (in_ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_result (out_alu_result),
    .out_zero       (out_zero),
    .out_write_data (out_write_data),
    .out_pc_branch  (out_pc_branch),
    .out_rd         (out_rd),
    .out_ctrl       (out_ctrl),
    .branch_taken   (branch_taken)
  );

  typedef struct packed {
    logic [DW-1:0] alu;
    logic          zero;
    logic [DW-1:0] wdata;
    logic [DW-1:0] pcb;
    logic [RW-1:0] rd;
    logic [4:0]    ctrl;
  } ent_t;

  typedef struct {
    logic          v;
    logic [DW-1:0] alu;
    logic          ordy;
    logic          eov;
    logic          eir;
    logic [DW-1:0] ealu;
  } vec_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] alu, input logic z,
                       input logic [DW-1:0] wd, input logic [DW-1:0] pcb,
                       input logic [RW-1:0] rd, input logic [4:0] ctrl,
                       input logic ordy, input logic fl);
    in_valid      = v;
    in_alu_result = alu;
    in_zero       = z;
    in_write_data = wd;
    in_pc_branch  = pcb;
    in_rd         = rd;
    in_ctrl       = ctrl;
    out_ready     = ordy;
    flush         = fl;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, 1'b0, '0, '0, '0, 5'b0, ordy, 1'b0);
  endtask

  // Called at a falling edge after inputs are driven: compares the DUT head
  // with the scoreboard, advances the model across the next rising edge,
  // and returns at the following falling edge.
  task automatic step();
    ent_t h;
    ent_t e;
    logic exp_ov;
    logic exp_ir;
    logic acc;
    logic pp;
    exp_ov = (q.size() > 0);
    exp_ir = (q.size() < 2);
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, exp_ir);
    if (exp_ov) begin
      h = q[0];
      chk("out_alu_result", out_alu_result, h.alu);
      chk("out_zero", out_zero, h.zero);
      chk("out_write_data", out_write_data, h.wdata);
      chk("out_pc_branch", out_pc_branch, h.pcb);
      chk("out_rd", out_rd, h.rd);
      chk("out_ctrl", out_ctrl, h.ctrl);
      chk("branch_taken", branch_taken, h.ctrl[4] & h.zero);
    end else begin
      chk("branch_taken_idle", branch_taken, 1'b0);
    end
    acc = in_valid & exp_ir;
    pp  = exp_ov & out_ready;
    e   = '{alu: in_alu_result, zero: in_zero, wdata: in_write_data,
            pcb: in_pc_branch, rd: in_rd, ctrl: in_ctrl};
    if (flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[14];

  initial begin
    logic [DW-1:0] snap_alu;
    logic [DW-1:0] snap_pcb;
    logic [RW-1:0] snap_rd;

    // Streaming (rows 0-5) then backpressure A/B/C (rows 6-13).
    vecs[0]  = '{1'b1, 64'h1,  1'b1, 1'b0, 1'b1, 64'h0};
    vecs[1]  = '{1'b1, 64'h2,  1'b1, 1'b1, 1'b1, 64'h1};
    vecs[2]  = '{1'b1, 64'h3,  1'b1, 1'b1, 1'b1, 64'h2};
    vecs[3]  = '{1'b1, 64'h4,  1'b1, 1'b1, 1'b1, 64'h3};
    vecs[4]  = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h4};
    vecs[5]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 64'h0};
    vecs[6]  = '{1'b1, 64'hAA, 1'b0, 1'b0, 1'b1, 64'h0};
    vecs[7]  = '{1'b1, 64'hBB, 1'b0, 1'b1, 1'b1, 64'hAA};
    vecs[8]  = '{1'b1, 64'hCC, 1'b0, 1'b1, 1'b0, 64'hAA};
    vecs[9]  = '{1'b1, 64'hCC, 1'b0, 1'b1, 1'b0, 64'hAA};
    vecs[10] = '{1'b1, 64'hCC, 1'b1, 1'b1, 1'b0, 64'hAA};
    vecs[11] = '{1'b1, 64'hCC, 1'b1, 1'b1, 1'b1, 64'hBB};
    vecs[12] = '{1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'hCC};
    vecs[13] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 64'h0};

    // ---------------- reset state ----------------
    reset = 1'b1;
    idle(1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_alu", out_alu_result, 64'h0);
    chk("rst_ctrl", out_ctrl, 5'b0);
    chk("rst_branch", branch_taken, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // ---------------- reset mid-stream ----------------
    drive(1'b1, 64'h10, 1'b1, 64'h5, 64'h7, 5'd3, 5'b10000, 1'b0, 1'b0);
    step();
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_branch", branch_taken, 1'b0);
    chk("midrst_alu", out_alu_result, 64'h0);
    q.delete();
    idle(1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    repeat (3) step();

    // ---------------- table: streaming + backpressure ----------------
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v, vecs[i].alu, 1'b0, vecs[i].alu ^ 64'hFF00, 64'h0,
            vecs[i].alu[4:0], 5'b00011, vecs[i].ordy, 1'b0);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].eov);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].eir);
      if (vecs[i].eov) chk($sformatf("vec%0d_alu", i), out_alu_result, vecs[i].ealu);
      step();
    end

    // ---------------- branch resolution ----------------
    drive(1'b1, 64'h20, 1'b1, 64'h0, 64'h400, 5'd0, 5'b10000, 1'b0, 1'b0);
    step();
    idle(1'b1);
    chk("br_taken", branch_taken, 1'b1);
    chk("br_target", out_pc_branch, 64'h400);
    step();
    drive(1'b1, 64'h20, 1'b0, 64'h0, 64'h400, 5'd0, 5'b10000, 1'b0, 1'b0);
    step();
    idle(1'b1);
    chk("br_not_taken", branch_taken, 1'b0);
    chk("br_nt_valid", out_valid, 1'b1);
    step();
    step();

    // ---------------- flush with simultaneous events ----------------
    drive(1'b1, 64'h31, 1'b1, 64'h1, 64'h800, 5'd1, 5'b10000, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h32, 1'b0, 64'h2, 64'h0, 5'd2, 5'b01011, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h33, 1'b1, 64'h3, 64'h0, 5'd3, 5'b10000, 1'b1, 1'b1);
    step();
    idle(1'b1);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_branch", branch_taken, 1'b0);
    repeat (3) step();

    // ---------------- stability under stall ----------------
    drive(1'b1, 64'h1000, 1'b0, 64'hDEAD, 64'h44, 5'd9, 5'b00100, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h2000, 1'b0, 64'hBEEF, 64'h55, 5'd10, 5'b01011, 1'b0, 1'b0);
    step();
    idle(1'b0);
    snap_alu = out_alu_result;
    snap_pcb = out_pc_branch;
    snap_rd  = out_rd;
    for (int c = 0; c < 5; c++) begin
      chk("stall_wdata", out_write_data, 64'hDEAD);
      chk("stall_ctrl", out_ctrl, 5'b00100);
      chk("stall_alu", out_alu_result, snap_alu);
      chk("stall_pcb", out_pc_branch, snap_pcb);
      chk("stall_rd", out_rd, snap_rd);
      step();
    end
    idle(1'b1);
    step();
    idle(1'b0);
    chk("one_pop_valid", out_valid, 1'b1);
    chk("one_pop_alu", out_alu_result, 64'h2000);
    chk("one_pop_in_ready", in_ready, 1'b1);
    step();
    idle(1'b1);
    repeat (2) step();
    chk("drained", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ex_mem_stage
`default_nettype wire
